// File: rtl/xsim_msg_beat_serializer.sv
// Frames header + payload messages into a 32-bit beat stream through a small output FIFO.
// Over-length messages are consumed without producing any beats.
module xsim_msg_beat_serializer #(
  parameter logic [31:0] PORTAL     = 32'd0,
  parameter int          MAX_WORDS  = 1023,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [15:0] hdr_method,
  input  logic [15:0] hdr_words,
  input  logic        pay_valid,
  output logic        pay_ready,
  input  logic [31:0] pay_data,
  input  logic        beat_rdy,
  output logic        en_beat,
  output logic [31:0] beat,
  output logic [31:0] portal,
  output logic        busy,
  output logic        err_len
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_PAY, S_DROP} state_e;

  state_e        state_q, state_d;
  logic [15:0]   remaining_q, remaining_d;
  logic          err_len_q, err_len_d;
  logic          run_q;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic          empty, full, push_ok, push, over_len, hdr_acc, pay_acc;
  logic [31:0]   push_data;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign en_beat  = !empty && beat_rdy;
  assign beat     = empty ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok  = !full || en_beat;
  assign over_len = (hdr_words > MAX_W);
  assign hdr_acc  = hdr_valid && hdr_ready;
  assign pay_acc  = pay_valid && pay_ready;
  assign portal   = PORTAL;
  assign busy     = (state_q != S_IDLE) || !empty;
  assign err_len  = err_len_q;

  // run_q keeps both ready outputs low while reset is held and for the first edge after it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      remaining_q <= 16'd0;
      err_len_q   <= 1'b0;
      run_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      err_len_q   <= err_len_d;
      run_q       <= 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(en_beat);
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    err_len_d   = err_len_q;
    case (state_q)
      S_IDLE: begin
        if (hdr_acc) begin
          if (over_len) begin
            err_len_d   = 1'b1;
            remaining_d = hdr_words;
            state_d     = S_DROP;
          end else if (hdr_words != 16'd0) begin
            remaining_d = hdr_words;
            state_d     = S_PAY;
          end
        end
      end
      S_PAY, S_DROP: begin
        if (pay_acc) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hdr_ready = 1'b0;
    pay_ready = 1'b0;
    if (run_q) begin
      case (state_q)
        S_IDLE:  hdr_ready = push_ok;
        S_PAY:   pay_ready = push_ok;
        S_DROP:  pay_ready = 1'b1;
        default: ;
      endcase
    end
  end

  // Header beat carries the total frame length (header + payload) in its low half.
  always_comb begin
    push      = 1'b0;
    push_data = 32'd0;
    if (state_q == S_IDLE && hdr_acc && !over_len) begin
      push      = 1'b1;
      push_data = {hdr_method, hdr_words + 16'd1};
    end else if (state_q == S_PAY && pay_acc) begin
      push      = 1'b1;
      push_data = pay_data;
    end
  end

endmodule
